// File: rtl/router_pkt_fifo.sv
// Packet-aware output-channel FIFO: stores {header_flag, data} words, tracks the
// packet length on pops to flag orphan words, and reports fill level and almost-full.
module router_pkt_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_SIZE  = $clog2(DEPTH),
    parameter int LEN_MSB    = 7,
    parameter int LEN_LSB    = 2,
    parameter int AF_MARGIN  = 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  read_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] din,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  orphan,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic [ADDR_SIZE:0]    fill_level
);

    localparam int PW = ADDR_SIZE + 1;
    localparam int CW = LEN_MSB - LEN_LSB + 2;
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - AF_MARGIN);

    logic [DATA_WIDTH:0] mem [DEPTH];
    logic [PW-1:0]       wr_ptr;
    logic [PW-1:0]       rd_ptr;
    logic                hdr_q;
    logic [CW-1:0]       pkt_cnt;
    logic                wr_acc;
    logic                rd_acc;
    logic [DATA_WIDTH:0] rd_word;

    assign fill_level  = wr_ptr - rd_ptr;
    assign empty       = (wr_ptr == rd_ptr);
    assign full        = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                         (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
    assign almost_full = (fill_level >= AF_LEVEL);

    // write_enb/read_enb are requests; a write is taken only when !full and a read
    // only when !empty (flags as seen at the start of the cycle), and neither is
    // taken in a soft_reset cycle. An accepted read shows its result for one cycle.
    assign wr_acc  = write_enb && !full && !soft_reset;
    assign rd_acc  = read_enb && !empty && !soft_reset;
    assign rd_word = mem[rd_ptr[ADDR_SIZE-1:0]];

    // Storage has no reset; only pointers define what is valid.
    always_ff @(posedge clock) begin
        if (resetn && wr_acc) begin
            mem[wr_ptr[ADDR_SIZE-1:0]] <= {hdr_q, din};
        end
    end

    always_ff @(posedge clock) begin
        if (!resetn || soft_reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            hdr_q      <= 1'b0;
            pkt_cnt    <= '0;
            data_out   <= '0;
            data_valid <= 1'b0;
            orphan     <= 1'b0;
        end else begin
            hdr_q      <= lfd_state;
            data_valid <= 1'b0;
            orphan     <= 1'b0;
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + PW'(1);
                if (rd_word[DATA_WIDTH]) begin
                    // A header always restarts the count: payload plus parity.
                    pkt_cnt    <= CW'(rd_word[LEN_MSB:LEN_LSB]) + CW'(1);
                    data_out   <= rd_word[DATA_WIDTH-1:0];
                    data_valid <= 1'b1;
                end else if (pkt_cnt != '0) begin
                    pkt_cnt    <= pkt_cnt - CW'(1);
                    data_out   <= rd_word[DATA_WIDTH-1:0];
                    data_valid <= 1'b1;
                end else begin
                    orphan <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Bench for router_pkt_fifo: queue-based reference model, expected pop results
// scoreboarded and compared by a negedge monitor together with the level flags.
module tb_router_pkt_fifo;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = $clog2(DEPTH);

    logic          clock;
    logic          resetn;
    logic          soft_reset;
    logic          write_enb;
    logic          read_enb;
    logic          lfd_state;
    logic [DW-1:0] din;
    logic [DW-1:0] data_out;
    logic          data_valid;
    logic          orphan;
    logic          full;
    logic          empty;
    logic          almost_full;
    logic [AW:0]   fill_level;

    router_pkt_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .soft_reset  (soft_reset),
        .write_enb   (write_enb),
        .read_enb    (read_enb),
        .lfd_state   (lfd_state),
        .din         (din),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .orphan      (orphan),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .fill_level  (fill_level)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // reference model state
    logic [DW:0]   m_q[$];
    int            m_pkt;
    logic          m_hdr;
    logic [DW-1:0] m_dout;
    logic [DW+1:0] exp_q[$];   // {data_valid, orphan, data_out}

    int n_pass  = 0;
    int n_total = 0;
    bit mon_on  = 1'b0;

    task automatic check(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    endtask

    task automatic model_step(input logic we, input logic re, input logic lfd,
                              input logic sr, input logic rst, input logic [DW-1:0] d);
        logic [DW:0] w;
        bit was_full, was_empty;
        if (rst || sr) begin
            m_q.delete();
            m_pkt  = 0;
            m_hdr  = 1'b0;
            m_dout = '0;
            return;
        end
        was_full  = (m_q.size() == DEPTH);
        was_empty = (m_q.size() == 0);
        if (re && !was_empty) begin
            w = m_q.pop_front();
            if (w[DW]) begin
                m_pkt  = int'(w[7:2]) + 1;
                m_dout = w[DW-1:0];
                exp_q.push_back({1'b1, 1'b0, m_dout});
            end else if (m_pkt > 0) begin
                m_pkt--;
                m_dout = w[DW-1:0];
                exp_q.push_back({1'b1, 1'b0, m_dout});
            end else begin
                exp_q.push_back({1'b0, 1'b1, m_dout});
            end
        end
        if (we && !was_full) m_q.push_back({m_hdr, d});
        m_hdr = lfd;
    endtask

    // driver: inputs change on the falling edge, model advances just after the rising edge
    task automatic drive(input logic we, input logic re, input logic lfd,
                         input logic sr, input logic rst, input logic [DW-1:0] d);
        @(negedge clock);
        write_enb  = we;
        read_enb   = re;
        lfd_state  = lfd;
        soft_reset = sr;
        resetn     = !rst;
        din        = d;
        @(posedge clock);
        #1;
        model_step(we, re, lfd, sr, rst, d);
    endtask

    task automatic do_reset();
        drive(0, 0, 0, 0, 1, '0);
        drive(0, 0, 0, 0, 1, '0);
    endtask

    task automatic wr(input logic [DW-1:0] d);   drive(1, 0, 0, 0, 0, d);  endtask
    task automatic rd();                          drive(0, 1, 0, 0, 0, '0); endtask
    task automatic rw(input logic [DW-1:0] d);   drive(1, 1, 0, 0, 0, d);  endtask
    task automatic hdr_mark();                    drive(0, 0, 1, 0, 0, '0); endtask
    task automatic idle();                        drive(0, 0, 0, 0, 0, '0); endtask

    // monitor / scoreboard
    always @(negedge clock) begin
        logic [DW+1:0] e;
        if (mon_on) begin
            check("fill_level", int'(fill_level), m_q.size());
            check("empty", int'(empty), int'(m_q.size() == 0));
            check("full", int'(full), int'(m_q.size() == DEPTH));
            check("almost_full", int'(almost_full), int'(m_q.size() >= DEPTH - 2));
            if (data_valid || orphan) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", int'({data_valid, orphan, data_out}), 0);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_result", int'({data_valid, orphan, data_out}), int'(e));
                end
            end else begin
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("missing_output", int'({data_valid, orphan, data_out}), int'(e));
                end
                check("held_data_out", int'(data_out), int'(m_dout));
            end
        end
    end

    initial begin
        logic [DW-1:0] pkt[5];
        pkt[0] = 8'h0C; pkt[1] = 8'h11; pkt[2] = 8'h22; pkt[3] = 8'h33; pkt[4] = 8'hAA;
        write_enb = 0; read_enb = 0; lfd_state = 0; soft_reset = 0; resetn = 0; din = '0;
        do_reset();
        mon_on = 1'b1;
        idle();

        // header tagging: length-3 packet plus parity
        hdr_mark();
        for (int i = 0; i < 5; i++) wr(pkt[i]);
        for (int i = 0; i < 5; i++) rd();
        idle();

        // fill to full with a length-14 header packet, then a dropped 17th write
        do_reset();
        hdr_mark();
        wr(8'h38);
        for (int i = 0; i < 15; i++) wr(8'($urandom_range(0, 255)));
        wr(8'hEE);
        rw(8'hDD);                                  // full: write dropped, fill 15
        while (m_q.size() > 5) rd();
        rw(8'h77);                                  // fill stays 5
        while (m_q.size() > 0) rd();
        idle();

        // orphan word
        do_reset();
        wr(8'h55);
        rd();
        idle();

        // soft reset mid-packet, then a fresh packet
        do_reset();
        hdr_mark();
        for (int i = 0; i < 5; i++) wr(pkt[i]);
        rd();
        rd();
        drive(1, 1, 0, 1, 0, 8'h99);
        idle();
        rd();                                       // empty: ignored
        hdr_mark();
        for (int i = 0; i < 5; i++) wr(pkt[i] ^ 8'h40);
        for (int i = 0; i < 5; i++) rd();
        idle();

        // wrap-around at fill level 3
        do_reset();
        hdr_mark();
        wr(8'hFC);                                  // length 63 keeps the words valid
        wr(8'h01);
        wr(8'h02);
        for (int i = 0; i < 40; i++) rw(8'($urandom_range(0, 255)));
        for (int i = 0; i < 3; i++) rd();
        idle();

        // random traffic with occasional headers and soft resets
        for (int i = 0; i < 400; i++) begin
            drive(logic'($urandom_range(0, 99) < 60), logic'($urandom_range(0, 99) < 50),
                  logic'($urandom_range(0, 5) == 0), logic'($urandom_range(0, 59) == 0),
                  1'b0, 8'($urandom_range(0, 255)));
        end
        while (m_q.size() > 0) rd();
        idle();
        idle();

        check("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
